// File: rtl/g1_table_updater.sv
// Write-side controller for one G1 rule table: handles insert/delete/clear commands,
// tracks slot occupancy, allocates the lowest free slot and drives the table write port.
module g1_table_updater #(
  parameter int unsigned TABLE_ENTRY_SIZE = 154,
  parameter int unsigned INDEX_BIT_LEN    = 11,
  parameter int unsigned COMMAND_BIT_LEN  = 2,
  parameter int unsigned ENTRY_DATA_WIDTH = 171,
  parameter int unsigned PRELOAD_COUNT    = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [COMMAND_BIT_LEN-1:0]  cmd_op_i,
  input  logic [INDEX_BIT_LEN-1:0]    cmd_index_i,
  input  logic [31:0]                 cmd_src_ip_i,
  input  logic [5:0]                  cmd_src_len_i,
  input  logic [31:0]                 cmd_dst_ip_i,
  input  logic [5:0]                  cmd_dst_len_i,
  input  logic [15:0]                 cmd_sp_lo_i,
  input  logic [15:0]                 cmd_sp_hi_i,
  input  logic [15:0]                 cmd_dp_lo_i,
  input  logic [15:0]                 cmd_dp_hi_i,
  input  logic [7:0]                  cmd_proto_i,
  input  logic                        cmd_proto_wc_i,
  input  logic [INDEX_BIT_LEN-1:0]    cmd_rule_id_i,
  input  logic [INDEX_BIT_LEN-1:0]    cmd_next_i,
  output logic                        we_o,
  output logic [ENTRY_DATA_WIDTH-1:0] din_o,
  output logic [INDEX_BIT_LEN-1:0]    wr_index_o,
  output logic                        busy_o,
  output logic                        rsp_valid_o,
  output logic [INDEX_BIT_LEN-1:0]    rsp_index_o,
  output logic [1:0]                  rsp_status_o,
  output logic [INDEX_BIT_LEN-1:0]    free_count_o
);

  localparam int unsigned SlotW = $clog2(TABLE_ENTRY_SIZE + 1);
  localparam logic [INDEX_BIT_LEN-1:0] LastIdx   = INDEX_BIT_LEN'(TABLE_ENTRY_SIZE);
  localparam logic [INDEX_BIT_LEN-1:0] FreeAll   = INDEX_BIT_LEN'(TABLE_ENTRY_SIZE + 1);
  localparam logic [INDEX_BIT_LEN-1:0] FreeReset =
      INDEX_BIT_LEN'(TABLE_ENTRY_SIZE + 1 - PRELOAD_COUNT);
  localparam logic [INDEX_BIT_LEN-1:0] One       = INDEX_BIT_LEN'(1);

  localparam logic [COMMAND_BIT_LEN-1:0] OpNop    = COMMAND_BIT_LEN'(0);
  localparam logic [COMMAND_BIT_LEN-1:0] OpInsert = COMMAND_BIT_LEN'(1);
  localparam logic [COMMAND_BIT_LEN-1:0] OpDelete = COMMAND_BIT_LEN'(2);

  localparam logic [1:0] StsOk       = 2'b00;
  localparam logic [1:0] StsFull     = 2'b01;
  localparam logic [1:0] StsBadIndex = 2'b10;
  localparam logic [1:0] StsNotAlloc = 2'b11;

  typedef enum logic [2:0] {StIdle, StScan, StWrite, StClear, StResp} state_e;

  state_e                        state_q;
  logic [TABLE_ENTRY_SIZE:0]     bitmap_q;
  logic [INDEX_BIT_LEN-1:0]      free_q;
  logic [INDEX_BIT_LEN-1:0]      ptr_q;
  logic                          is_insert_q;
  logic [ENTRY_DATA_WIDTH-1:0]   entry_q;
  logic                          we_q;
  logic [ENTRY_DATA_WIDTH-1:0]   din_q;
  logic [INDEX_BIT_LEN-1:0]      wr_index_q;
  logic                          rsp_valid_q;
  logic [INDEX_BIT_LEN-1:0]      rsp_index_q;
  logic [1:0]                    rsp_status_q;

  logic [ENTRY_DATA_WIDTH-1:0]   entry_pack;
  logic [SlotW-1:0]              ptr_slot;
  logic [SlotW-1:0]              del_slot;

  assign entry_pack = {cmd_next_i, cmd_rule_id_i, cmd_proto_wc_i, cmd_proto_i,
                       cmd_dp_lo_i, cmd_dp_hi_i, cmd_sp_lo_i, cmd_sp_hi_i,
                       cmd_dst_len_i, cmd_dst_ip_i, cmd_src_len_i, cmd_src_ip_i};
  // Indices are range-checked before use, so the low bits address the bitmap.
  assign ptr_slot = ptr_q[SlotW-1:0];
  assign del_slot = cmd_index_i[SlotW-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      for (int unsigned i = 0; i <= TABLE_ENTRY_SIZE; i++) begin
        bitmap_q[i] <= (i < PRELOAD_COUNT);
      end
      free_q       <= FreeReset;
      ptr_q        <= '0;
      is_insert_q  <= 1'b0;
      entry_q      <= '0;
      we_q         <= 1'b0;
      din_q        <= '0;
      wr_index_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_index_q  <= '0;
      rsp_status_q <= StsOk;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            if (cmd_op_i == OpNop) begin
              state_q      <= StResp;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= StsOk;
              rsp_index_q  <= '0;
            end else if (cmd_op_i == OpInsert) begin
              entry_q     <= entry_pack;
              is_insert_q <= 1'b1;
              ptr_q       <= '0;
              state_q     <= StScan;
            end else if (cmd_op_i == OpDelete) begin
              if (cmd_index_i > LastIdx || !bitmap_q[del_slot]) begin
                state_q      <= StResp;
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= (cmd_index_i > LastIdx) ? StsBadIndex : StsNotAlloc;
                rsp_index_q  <= '0;
              end else begin
                is_insert_q <= 1'b0;
                ptr_q       <= cmd_index_i;
                we_q        <= 1'b1;
                wr_index_q  <= cmd_index_i;
                din_q       <= '0;
                state_q     <= StWrite;
              end
            end else begin
              ptr_q      <= '0;
              we_q       <= 1'b1;
              wr_index_q <= '0;
              din_q      <= '0;
              state_q    <= StClear;
            end
          end
        end
        StScan: begin
          if (!bitmap_q[ptr_slot]) begin
            we_q       <= 1'b1;
            wr_index_q <= ptr_q;
            din_q      <= entry_q;
            state_q    <= StWrite;
          end else if (ptr_q == LastIdx) begin
            state_q      <= StResp;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= StsFull;
            rsp_index_q  <= '0;
          end else begin
            ptr_q <= ptr_q + One;
          end
        end
        StWrite: begin
          we_q               <= 1'b0;
          bitmap_q[ptr_slot] <= is_insert_q;
          free_q             <= is_insert_q ? free_q - One : free_q + One;
          state_q            <= StResp;
          rsp_valid_q        <= 1'b1;
          rsp_status_q       <= StsOk;
          rsp_index_q        <= ptr_q;
        end
        StClear: begin
          if (ptr_q == LastIdx) begin
            we_q         <= 1'b0;
            bitmap_q     <= '0;
            free_q       <= FreeAll;
            state_q      <= StResp;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= StsOk;
            rsp_index_q  <= '0;
          end else begin
            ptr_q      <= ptr_q + One;
            wr_index_q <= ptr_q + One;
          end
        end
        StResp: begin
          rsp_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign we_o         = we_q;
  assign din_o        = din_q;
  assign wr_index_o   = wr_index_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_index_o  = rsp_index_q;
  assign rsp_status_o = rsp_status_q;
  assign free_count_o = free_q;

endmodule

// File: tb/tb_g1_table_updater.sv
// Directed bench for g1_table_updater: one instance with no preload, one with three
// preloaded slots, sharing the command bus and reset.
module tb_g1_table_updater;

  logic clk = 1'b0;
  logic rst;
  logic v0, v3;
  logic [1:0]  op;
  logic [10:0] idx, rid, nxt;
  logic [31:0] sip, dip;
  logic [5:0]  sl, dl;
  logic [15:0] spl, sph, dpl, dph;
  logic [7:0]  pr;
  logic        pwc;

  logic         d0_rdy, d0_we, d0_busy, d0_rv;
  logic [170:0] d0_din;
  logic [10:0]  d0_wri, d0_ri, d0_fc;
  logic [1:0]   d0_rs;
  logic         d3_rdy, d3_we, d3_busy, d3_rv;
  logic [170:0] d3_din;
  logic [10:0]  d3_wri, d3_ri, d3_fc;
  logic [1:0]   d3_rs;

  always #5 clk = ~clk;

  g1_table_updater #(.PRELOAD_COUNT(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(v0), .cmd_ready_o(d0_rdy), .cmd_op_i(op),
    .cmd_index_i(idx), .cmd_src_ip_i(sip), .cmd_src_len_i(sl), .cmd_dst_ip_i(dip),
    .cmd_dst_len_i(dl), .cmd_sp_lo_i(spl), .cmd_sp_hi_i(sph), .cmd_dp_lo_i(dpl),
    .cmd_dp_hi_i(dph), .cmd_proto_i(pr), .cmd_proto_wc_i(pwc), .cmd_rule_id_i(rid),
    .cmd_next_i(nxt), .we_o(d0_we), .din_o(d0_din), .wr_index_o(d0_wri),
    .busy_o(d0_busy), .rsp_valid_o(d0_rv), .rsp_index_o(d0_ri), .rsp_status_o(d0_rs),
    .free_count_o(d0_fc)
  );

  g1_table_updater #(.PRELOAD_COUNT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(v3), .cmd_ready_o(d3_rdy), .cmd_op_i(op),
    .cmd_index_i(idx), .cmd_src_ip_i(sip), .cmd_src_len_i(sl), .cmd_dst_ip_i(dip),
    .cmd_dst_len_i(dl), .cmd_sp_lo_i(spl), .cmd_sp_hi_i(sph), .cmd_dp_lo_i(dpl),
    .cmd_dp_hi_i(dph), .cmd_proto_i(pr), .cmd_proto_wc_i(pwc), .cmd_rule_id_i(rid),
    .cmd_next_i(nxt), .we_o(d3_we), .din_o(d3_din), .wr_index_o(d3_wri),
    .busy_o(d3_busy), .rsp_valid_o(d3_rv), .rsp_index_o(d3_ri), .rsp_status_o(d3_rs),
    .free_count_o(d3_fc)
  );

  int n_total = 0;
  int n_bad   = 0;

  int           we_cnt, we_cyc, rsp_cyc, clr_err, rdy_err, fill_err;
  logic [170:0] din_cap, exp_din;
  logic [10:0]  wri_cap, ri_cap;
  logic [1:0]   rs_cap;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Rule fields derived from rule_id; expected entry assembled slice by slice.
  task automatic set_rule(input logic [10:0] r, input logic [10:0] n);
    rid = r; nxt = n;
    sip = 32'hC0A8_0000 | 32'(r); sl = 6'd24; dip = 32'h0A00_0001 ^ {21'd0, r}; dl = 6'd16;
    spl = 16'd1000; sph = 16'd2000 + 16'(r); dpl = 16'd80; dph = 16'd443;
    pr = 8'd6; pwc = r[0];
    exp_din = '0;
    exp_din[31:0] = sip;     exp_din[37:32] = sl;     exp_din[69:38] = dip;
    exp_din[75:70] = dl;     exp_din[91:76] = sph;    exp_din[107:92] = spl;
    exp_din[123:108] = dph;  exp_din[139:124] = dpl;  exp_din[147:140] = pr;
    exp_din[148] = pwc;      exp_din[159:149] = r;    exp_din[170:160] = n;
  endtask

  // Issue one command; cycle c counts from the accept edge (cycle 0).
  task automatic do_cmd(input bit sel, input logic [1:0] o, input logic [10:0] ix,
                        input int limit);
    logic s_we, s_rv, s_rdy;
    logic [10:0] s_wri;
    logic [170:0] s_din;
    @(negedge clk);
    op = o; idx = ix;
    if (sel) v3 = 1'b1; else v0 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0; v3 = 1'b0;
    we_cnt = 0; we_cyc = -1; rsp_cyc = -1; clr_err = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      s_we  = sel ? d3_we  : d0_we;
      s_rv  = sel ? d3_rv  : d0_rv;
      s_rdy = sel ? d3_rdy : d0_rdy;
      s_wri = sel ? d3_wri : d0_wri;
      s_din = sel ? d3_din : d0_din;
      if (s_rdy) rdy_err++;
      if (s_we) begin
        if (we_cnt == 0) begin
          we_cyc = c; wri_cap = s_wri; din_cap = s_din;
        end
        if (s_wri != 11'(we_cnt) || s_din != '0) clr_err++;
        we_cnt++;
      end
      if (s_rv) begin
        rsp_cyc = c;
        rs_cap  = sel ? d3_rs : d0_rs;
        ri_cap  = sel ? d3_ri : d0_ri;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b0; v3 = 1'b0; op = 2'd0; idx = '0; rdy_err = 0; fill_err = 0;
    set_rule(11'd0, 11'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", d0_rdy, 1);
    check_eq("rst_we_busy_rv", {d0_we, d0_busy, d0_rv}, 0);
    check_eq("rst_wri_din", {d0_wri, d0_din[63:0]}, 0);
    check_eq("rst_free0", d0_fc, 155);
    check_eq("rst_free3", d3_fc, 152);

    // First insert into empty table lands in slot 0.
    set_rule(11'd5, 11'd0);
    do_cmd(0, 2'b01, 11'd0, 20);
    check_eq("ins0_we_cyc", we_cyc, 2);
    check_eq("ins0_wri", wri_cap, 0);
    check_eq("ins0_rule", din_cap[159:149], 5);
    check_eq("ins0_din", din_cap == exp_din, 1);
    check_eq("ins0_rsp_cyc", rsp_cyc, 3);
    check_eq("ins0_rsp", {rs_cap, ri_cap}, {2'b00, 11'd0});
    check_eq("ins0_free", d0_fc, 154);
    check_eq("ins0_we_cnt", we_cnt, 1);

    set_rule(11'd9, 11'd3);
    do_cmd(0, 2'b01, 11'd0, 20);
    check_eq("ins1_we_cyc", we_cyc, 3);
    check_eq("ins1_wri", wri_cap, 1);
    check_eq("ins1_din", din_cap == exp_din, 1);
    check_eq("ins1_rsp", {rsp_cyc[7:0], rs_cap, ri_cap}, {8'd4, 2'b00, 11'd1});

    do_cmd(0, 2'b10, 11'd200, 20);
    check_eq("del_bad", {rsp_cyc[7:0], rs_cap, ri_cap}, {8'd1, 2'b10, 11'd0});
    check_eq("del_bad_we", we_cnt, 0);
    do_cmd(0, 2'b10, 11'd50, 20);
    check_eq("del_na", {rsp_cyc[7:0], rs_cap, ri_cap}, {8'd1, 2'b11, 11'd0});
    check_eq("del_na_we", we_cnt, 0);

    do_cmd(0, 2'b10, 11'd0, 20);
    check_eq("del0_we", {we_cyc[7:0], wri_cap}, {8'd1, 11'd0});
    check_eq("del0_din", din_cap[63:0], 0);
    check_eq("del0_rsp", {rsp_cyc[7:0], rs_cap, ri_cap}, {8'd2, 2'b00, 11'd0});
    check_eq("del0_free", d0_fc, 154);

    set_rule(11'd7, 11'd1);
    do_cmd(0, 2'b01, 11'd0, 20);
    check_eq("reins_slot", {we_cyc[7:0], wri_cap}, {8'd2, 11'd0});
    do_cmd(0, 2'b00, 11'd0, 20);
    check_eq("nop", {rsp_cyc[7:0], rs_cap, ri_cap, we_cnt[7:0]}, {8'd1, 2'b00, 11'd0, 8'd0});

    // Preloaded instance: free slot 1, refill lands there.
    do_cmd(1, 2'b10, 11'd1, 20);
    check_eq("p3_del", {rsp_cyc[7:0], rs_cap, ri_cap}, {8'd2, 2'b00, 11'd1});
    check_eq("p3_del_free", d3_fc, 153);
    set_rule(11'd12, 11'd0);
    do_cmd(1, 2'b01, 11'd0, 20);
    check_eq("p3_ins", {we_cyc[7:0], wri_cap}, {8'd3, 11'd1});
    check_eq("p3_ins_free", d3_fc, 152);
    do_cmd(1, 2'b10, 11'd2, 20);
    check_eq("p3_del2", {rs_cap, ri_cap}, {2'b00, 11'd2});

    // Fill remaining slots 2..154 in order.
    for (int k = 2; k <= 154; k++) begin
      set_rule(11'(k), 11'(k + 1));
      do_cmd(0, 2'b01, 11'd0, 200);
      if (wri_cap != 11'(k) || rs_cap != 2'b00 || we_cyc != k + 2 || rsp_cyc != k + 3)
        fill_err++;
    end
    check_eq("fill_err", fill_err, 0);
    check_eq("fill_free", d0_fc, 0);
    do_cmd(0, 2'b01, 11'd0, 300);
    check_eq("full_rsp", {rsp_cyc[15:0], rs_cap, ri_cap}, {16'd156, 2'b01, 11'd0});
    check_eq("full_we", we_cnt, 0);
    check_eq("full_free", d0_fc, 0);

    do_cmd(0, 2'b11, 11'd0, 300);
    check_eq("clr_we_cnt", we_cnt, 155);
    check_eq("clr_seq", clr_err, 0);
    check_eq("clr_rsp", {rsp_cyc[15:0], rs_cap, ri_cap}, {16'd156, 2'b00, 11'd0});
    check_eq("clr_free", d0_fc, 155);
    set_rule(11'd33, 11'd0);
    do_cmd(0, 2'b01, 11'd0, 20);
    check_eq("clr_then_ins", {we_cyc[7:0], wri_cap}, {8'd2, 11'd0});
    check_eq("ready_while_busy", rdy_err, 0);

    // Reset while scanning: slot 0 occupied, so the scan is still running at the reset edge.
    @(negedge clk);
    op = 2'b01; v0 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstmid_out", {d0_we, d0_rv, d0_busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstmid_ready", d0_rdy, 1);
    check_eq("rstmid_free0", d0_fc, 155);
    check_eq("rstmid_free3", d3_fc, 152);
    we_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (d0_we || d0_rv) we_cnt++;
    end
    check_eq("rstmid_quiet", we_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
